// File: rtl/timer_pwm_slave_if.sv
// Register-bus port between the interconnect (master) and the timer/PWM peripheral (slave).
// Signal names match the original flat ports so the bus wiring is unchanged.
interface timer_pwm_slave_if;
    logic        i_WEnable;
    logic [31:0] i_WAddr;
    logic [31:0] i_WData;
    logic        i_REnable;
    logic [31:0] i_RAddr;
    logic [31:0] o_RData;

    modport master (
        output i_WEnable, i_WAddr, i_WData, i_REnable, i_RAddr,
        input  o_RData
    );

    modport slave (
        input  i_WEnable, i_WAddr, i_WData, i_REnable, i_RAddr,
        output o_RData
    );
endinterface

// File: rtl/timer_pwm_slave.sv
// Timer/PWM peripheral on a 4-register slave port: prescaled up-counter with periodic or
// one-shot mode, compare-driven PWM, sticky overflow interrupt, 1-cycle registered reads.
module timer_pwm_slave #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned PRE_WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    timer_pwm_slave_if.slave bus,
    output logic             o_Irq,
    output logic             o_Pwm
);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_PERIOD  = 2'd1,
        REG_COMPARE = 2'd2,
        REG_COUNT   = 2'd3
    } reg_idx_e;

    logic                 en_q, en_d;
    logic                 mode_q, mode_d;
    logic                 irq_en_q, irq_en_d;
    logic                 ovf_q, ovf_d;
    logic [PRE_WIDTH-1:0] pre_q, pre_d;
    logic [PRE_WIDTH-1:0] p_q, p_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] compare_q, compare_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]          rdata_q, rdata_d;

    reg_idx_e    widx, ridx;
    logic        wr_ctrl, wr_period, wr_compare, wr_count;
    logic        tick, wrap;
    logic [31:0] rd_val;
    logic        unused_addr_bits;

    assign widx       = reg_idx_e'(bus.i_WAddr[1:0]);
    assign ridx       = reg_idx_e'(bus.i_RAddr[1:0]);
    assign wr_ctrl    = bus.i_WEnable && (widx == REG_CTRL);
    assign wr_period  = bus.i_WEnable && (widx == REG_PERIOD);
    assign wr_compare = bus.i_WEnable && (widx == REG_COMPARE);
    assign wr_count   = bus.i_WEnable && (widx == REG_COUNT);

    assign unused_addr_bits = ^{bus.i_WAddr[31:2], bus.i_RAddr[31:2]};

    assign tick = en_q && (p_q == pre_q);
    assign wrap = tick && (count_q == period_q);

    // Hardware counting is resolved first; bus writes then override field by field.
    always_comb begin
        en_d      = en_q;
        mode_d    = mode_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q | wrap;
        pre_d     = pre_q;
        p_d       = p_q;
        period_d  = period_q;
        compare_d = compare_q;
        count_d   = count_q;

        if (en_q) begin
            p_d = tick ? '0 : p_q + 1'b1;
        end
        if (tick) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        if (wrap && mode_q) begin
            en_d = 1'b0;
        end

        if (wr_ctrl) begin
            en_d     = bus.i_WData[0];
            mode_d   = bus.i_WData[1];
            irq_en_d = bus.i_WData[2];
            pre_d    = bus.i_WData[8 +: PRE_WIDTH];
            if (bus.i_WData[4] && !wrap) begin
                ovf_d = 1'b0;
            end
            // Keep P inside the new range so a shrunken PRESCALE never waits for P to wrap.
            if (p_d > pre_d) begin
                p_d = '0;
            end
        end
        if (wr_period) begin
            period_d = bus.i_WData[CNT_WIDTH-1:0];
        end
        if (wr_compare) begin
            compare_d = bus.i_WData[CNT_WIDTH-1:0];
        end
        if (wr_count) begin
            count_d = bus.i_WData[CNT_WIDTH-1:0];
            p_d     = '0;
        end
    end

    always_comb begin
        rd_val = '0;
        case (ridx)
            REG_CTRL: begin
                rd_val[0]              = en_q;
                rd_val[1]              = mode_q;
                rd_val[2]              = irq_en_q;
                rd_val[4]              = ovf_q;
                rd_val[8 +: PRE_WIDTH] = pre_q;
            end
            REG_PERIOD:  rd_val[CNT_WIDTH-1:0] = period_q;
            REG_COMPARE: rd_val[CNT_WIDTH-1:0] = compare_q;
            REG_COUNT:   rd_val[CNT_WIDTH-1:0] = count_q;
            default:     rd_val = '0;
        endcase
        rdata_d = bus.i_REnable ? rd_val : rdata_q;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            pre_q     <= '0;
            p_q       <= '0;
            period_q  <= '0;
            compare_q <= '0;
            count_q   <= '0;
            rdata_q   <= '0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            pre_q     <= pre_d;
            p_q       <= p_d;
            period_q  <= period_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.o_RData = rdata_q;
    assign o_Irq       = ovf_q & irq_en_q;
    assign o_Pwm       = en_q & (count_q < compare_q);

endmodule
